fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshake.
//  Generalises the combinational single-precision multiplier: configurable exponent/mantissa widths,
//  pass-through tag, backpressure, NaN/Inf classification and registered per-result flags.
//  Sits between an operand-issue FIFO and the FPU writeback arbiter.
// PARAMETERS
//  EXP_W  8   exponent field width (>=3)
//  MAN_W  23  stored mantissa width, hidden bit excluded (>=2)
//  TAG_W  4   width of opaque tag carried alongside operands (>=1)
// PORTS
//  clk        in   1              single clock, all state on rising edge
//  rst_n      in   1              reset, synchronous, active-low
//  in_valid   in   1              operand pair valid
//  in_ready   out  1              block accepts operands this cycle
//  in_a       in   W=1+EXP_W+MAN_W  operand A {sign,exp,man}
//  in_b       in   W              operand B
//  in_tag     in   TAG_W          tag, returned unchanged with result
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  out_result out  W              product
//  out_tag    out  TAG_W          tag of this result
//  out_flags  out  4              {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valids 0; out_valid=0, out_result=0, out_tag=0, out_flags=0.
//    Reset mid-operation discards all in-flight results; none emerge afterwards.
//  - Pipeline enable adv = out_ready | ~out_valid; in_ready = adv (combinational). Whole pipe holds when adv=0.
//    Transfer on in_valid&in_ready; latency exactly 3 cycles with no stall; throughput 1/cycle.
//    Held outputs stay stable while out_valid&~out_ready. Bubbles advance like data.
//  - S1: unpack; sign = sa^sb; classify zero (exp=0, incl. subnormals: flushed to zero, DAZ),
//    inf (exp=all-ones, man=0), NaN (exp=all-ones, man!=0); esum = ea+eb-BIAS, BIAS=2^(EXP_W-1)-1,
//    computed signed at EXP_W+2 bits.
//  - S2: (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits.
//  - S3: if product MSB set, shift right 1 and esum+1. Guard = first dropped bit, sticky = OR of rest.
//    Round per CONFIGURATION; mantissa carry-out renormalises (man=0, exp+1).
//  - Special priority in S3 (highest first):
//    1. any NaN, or inf*zero -> canonical NaN {0,all-ones,1,0..0}, invalid=1
//    2. inf*nonzero -> {sign,all-ones,0}
//    3. zero operand -> {sign,0}
//    4. final exp >= 2^EXP_W-1 -> {sign,all-ones,0}, overflow=1, inexact=1
//    5. final exp <= 0 -> {sign,0}, underflow=1, inexact=1 (flush-to-zero)
//    6. else normal pack; inexact = guard|sticky.
//  - Flags are per-result, not sticky across results.
// CONFIGURATION
//  FP_MUL_RNE_EN defined: round-to-nearest-even (up if guard&(sticky|lsb)).
//  Undefined: round-half-up (up if guard), matching the legacy multiplier. Flags unaffected by macro.
// STRUCTURE
//  Package fp_pkg: fp_class_t enum {FP_ZERO,FP_NORM,FP_INF,FP_NAN}, flag bit index localparams,
//  bias/qNaN helper functions of EXP_W/MAN_W.
//  One sub-module fp_round_pack (S3 normalise/round/special-select, combinational); the top level holds
//  the stage registers and handshake.
// TESTING (EXP_W=8, MAN_W=23)
//  1. 0x40000000*0x40400000 -> 0x40C00000, flags 0, tag preserved, out 3 cycles after accept.
//  2. 0x3F800003*0x3FC00000 (tie) -> 0x3FC00004 with FP_MUL_RNE_EN, 0x3FC00005 without; inexact=1.
//  3. 0x7F000000*0x7F000000 -> 0x7F800000 overflow=1; 0x00800000*0x00800000 -> 0x00000000 underflow=1.
//  4. 0x7F800000*0x00000000 -> 0x7FC00000 invalid=1; 0xFF800000*0x40000000 -> 0xFF800000 flags 0.
//  5. Stream 8 ops with out_ready low cycles 4-7: in_ready low same cycles; no loss/dup; order and tags kept.
//  6. Assert rst_n=0 one cycle with 3 ops in flight -> out_valid=0 next cycle, no stale result emerges.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg -- shared types and helpers for the pipelined floating-point multiplier.
//   fp_class_t   : operand classification carried down the pipe
//   FLAG_*       : bit positions inside the 4-bit {invalid, overflow, underflow, inexact} flag word
//   fp_bias()    : exponent bias for a given exponent width
//   fp_qnan()    : canonical quiet NaN pattern {0, all-ones, 1, 0..0}, returned right-aligned in 64 bits
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Caller slices the low 1+exp_w+man_w bits.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack -- third-stage logic of fp_mul_pipe (purely combinational).
// Normalises the raw mantissa product, rounds, resolves special operands and
// packs the result with its per-result flags.
//   sign     in  result sign (sa ^ sb)
//   cls_a/b  in  operand classes
//   esum     in  signed biased exponent sum ea+eb-BIAS
//   prod     in  (MAN_W+1)x(MAN_W+1) mantissa product
//   result   out packed {sign, exp, man}
//   flags    out {invalid, overflow, underflow, inexact}
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even; otherwise round-half-up.
module fp_round_pack import fp_pkg::*; #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int P     = 2 * MAN_W + 2
) (
  input  logic                    sign,
  input  fp_class_t               cls_a,
  input  fp_class_t               cls_b,
  input  logic signed [EXP_W+1:0] esum,
  input  logic [P-1:0]            prod,
  output logic [W-1:0]            result,
  output logic [3:0]              flags
);

  localparam logic [63:0]             QNAN64  = fp_qnan(EXP_W, MAN_W);
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  logic [P-1:0]            norm;
  logic [MAN_W-1:0]        man;
  logic                    guard, sticky, up;
  logic [MAN_W:0]          man_r;
  logic signed [EXP_W+1:0] exp_f;
  logic                    any_nan, any_inf, any_zero;

  always_comb begin
    // Product of two [1,2) values lies in [1,4); align the leading one to bit P-1.
    norm   = prod[P-1] ? prod : (prod << 1);
    man    = norm[P-2 -: MAN_W];
    guard  = norm[P-2-MAN_W];
    sticky = |norm[P-3-MAN_W:0];
`ifdef FP_MUL_RNE_EN
    up     = guard & (sticky | man[0]);
`else
    up     = guard;
`endif
    // Carry out of the rounded mantissa leaves man_r[MAN_W-1:0] = 0 and bumps the exponent.
    man_r  = {1'b0, man} + {{MAN_W{1'b0}}, up};
    exp_f  = esum + (EXP_W+2)'(prod[P-1]) + (EXP_W+2)'(man_r[MAN_W]);

    any_nan  = (cls_a == FP_NAN)  || (cls_b == FP_NAN);
    any_inf  = (cls_a == FP_INF)  || (cls_b == FP_INF);
    any_zero = (cls_a == FP_ZERO) || (cls_b == FP_ZERO);

    result = '0;
    flags  = '0;
    if (any_nan || (any_inf && any_zero)) begin
      result              = QNAN64[W-1:0];
      flags[FLAG_INVALID] = 1'b1;
    end else if (any_inf) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      result = {sign, {(W-1){1'b0}}};
    end else if (exp_f >= EXP_MAX) begin
      result               = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f <= 0) begin
      // Flush-to-zero: no subnormal outputs.
      result                = {sign, {(W-1){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      result              = {sign, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
      flags[FLAG_INEXACT] = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- 3-stage pipelined floating-point multiplier with valid/ready handshake.
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready = out_ready | ~out_valid
//   in_a, in_b            operands {sign, exp, man}
//   in_tag                opaque tag returned with the result
//   out_valid/out_ready   result handshake
//   out_result, out_tag   product and its tag
//   out_flags             {invalid, overflow, underflow, inexact}
// Stages: S1 unpack/classify/exponent sum, S2 mantissa multiply, S3 round/pack (registered outputs).
// The whole pipe moves together, so a stall at the output freezes every stage.
// Subnormal inputs are treated as zero.
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even rounding (default round-half-up).
module fp_mul_pipe import fp_pkg::*; #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int TAG_W = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int STAGES = 3;
  localparam int P      = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(fp_bias(EXP_W));

  function automatic fp_class_t classify(input logic [W-1:0] x);
    if (x[W-2 -: EXP_W] == '0) return FP_ZERO;
    if (x[W-2 -: EXP_W] == '1) return (x[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  logic [STAGES:1] vld_pipe;
  logic            adv;

  logic                    s1_sign;
  fp_class_t               s1_cls_a, s1_cls_b;
  logic signed [EXP_W+1:0] s1_esum;
  logic [MAN_W:0]          s1_ma, s1_mb;
  logic [TAG_W-1:0]        s1_tag;

  logic                    s2_sign;
  fp_class_t               s2_cls_a, s2_cls_b;
  logic signed [EXP_W+1:0] s2_esum;
  logic [P-1:0]            s2_prod;
  logic [TAG_W-1:0]        s2_tag;

  logic signed [EXP_W+1:0] esum_d;
  logic [W-1:0]            s3_result;
  logic [3:0]              s3_flags;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign esum_d    = (EXP_W+2)'(in_a[W-2 -: EXP_W]) + (EXP_W+2)'(in_b[W-2 -: EXP_W]) - BIAS;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (s2_sign),
    .cls_a  (s2_cls_a),
    .cls_b  (s2_cls_b),
    .esum   (s2_esum),
    .prod   (s2_prod),
    .result (s3_result),
    .flags  (s3_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      s1_sign    <= 1'b0;
      s1_cls_a   <= FP_ZERO;
      s1_cls_b   <= FP_ZERO;
      s1_esum    <= '0;
      s1_ma      <= '0;
      s1_mb      <= '0;
      s1_tag     <= '0;
      s2_sign    <= 1'b0;
      s2_cls_a   <= FP_ZERO;
      s2_cls_b   <= FP_ZERO;
      s2_esum    <= '0;
      s2_prod    <= '0;
      s2_tag     <= '0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (adv) begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], in_valid};
      // S1
      s1_sign    <= in_a[W-1] ^ in_b[W-1];
      s1_cls_a   <= classify(in_a);
      s1_cls_b   <= classify(in_b);
      s1_esum    <= esum_d;
      s1_ma      <= {1'b1, in_a[MAN_W-1:0]};
      s1_mb      <= {1'b1, in_b[MAN_W-1:0]};
      s1_tag     <= in_tag;
      // S2
      s2_sign    <= s1_sign;
      s2_cls_a   <= s1_cls_a;
      s2_cls_b   <= s1_cls_b;
      s2_esum    <= s1_esum;
      s2_prod    <= P'(s1_ma) * P'(s1_mb);
      s2_tag     <= s1_tag;
      // S3
      out_result <= s3_result;
      out_tag    <= s2_tag;
      out_flags  <= s3_flags;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe -- self-checking bench for fp_mul_pipe (EXP_W=8, MAN_W=23, TAG_W=4).
// Reference model works on whole integers (exact product, remainder vs half-ulp) and a
// scoreboard queue keyed by accept order.
module tb_fp_mul_pipe;
  localparam int EXP_W = 8, MAN_W = 23, TAG_W = 4, W = 32;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [W-1:0]     in_a = '0, in_b = '0, out_result;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic             out_valid, out_ready = 1'b0;
  logic [3:0]       out_flags;

  int          checks = 0, failures = 0;
  int          n_acc = 0, n_out = 0;
  logic [39:0] sb[$];
  logic [39:0] mon_e;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {flags[3:0], result[31:0]}.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s, up;
    bit nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
    longint unsigned ma, mb, p, q, rem, half;
    ea = int'(a[30:23]); eb = int'(b[30:23]); s = a[31] ^ b[31];
    nan_a = (ea == 255) && (a[22:0] != 0); inf_a = (ea == 255) && (a[22:0] == 0); zer_a = (ea == 0);
    nan_b = (eb == 255) && (b[22:0] != 0); inf_b = (eb == 255) && (b[22:0] == 0); zer_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) return {4'b1000, 32'h7FC0_0000};
    if (inf_a || inf_b) return {4'b0000, s, 8'hFF, 23'h0};
    if (zer_a || zer_b) return {4'b0000, s, 31'h0};
    ma = 64'(a[22:0]) + 64'h80_0000;
    mb = 64'(b[22:0]) + 64'h80_0000;
    p  = ma * mb;
    e  = ea + eb - 127;
    sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
    if (sh == 24) e++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
`ifdef FP_MUL_RNE_EN
    up = (rem > half) || ((rem == half) && q[0]);
`else
    up = (rem >= half);
`endif
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, rem != 0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    int r;
    logic [31:0] specials [6];
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0123};
    r = $urandom_range(0, 15);
    if (r == 0) return specials[$urandom_range(0, 5)];
    if (r == 1) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  // Scoreboard: handshakes are judged mid-cycle, so they describe the coming edge.
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else begin
          mon_e = sb.pop_front();
          chk("sb_result", 64'(out_result), 64'(mon_e[31:0]));
          chk("sb_flags",  64'(out_flags),  64'(mon_e[35:32]));
          chk("sb_tag",    64'(out_tag),    64'(mon_e[39:36]));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_tag, ref_mul(in_a, in_b)});
        n_acc++;
      end
    end
  end

  // Called at posedge+1 with an empty pipe; checks 3-cycle latency against spec constants.
  task automatic dir_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] er, input logic [3:0] ef);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk({nm, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_valid"},  64'(out_valid),  64'd1);
    chk({nm, "_result"}, 64'(out_result), 64'(er));
    chk({nm, "_flags"},  64'(out_flags),  64'(ef));
    chk({nm, "_tag"},    64'(out_tag),    64'(tag));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
    chk({nm, "_count"},   64'(n_out),     64'(n_acc));
  endtask

  initial begin
    int sent, cyc;
    logic acc, seen;
    logic [31:0] a, b;

    #600000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, cyc;
    logic acc, seen;
    logic [31:0] a, b;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",  64'(out_valid),  64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_tag",    64'(out_tag),    64'd0);
    chk("rst_flags",  64'(out_flags),  64'd0);
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;

    // Directed cases
    dir_op("mul_2x3", 32'h4000_0000, 32'h4040_0000, 4'h5, 32'h40C0_0000, 4'h0);
`ifdef FP_MUL_RNE_EN
    dir_op("tie", 32'h3F80_0003, 32'h3FC0_0000, 4'h6, 32'h3FC0_0004, 4'h1);
`else
    dir_op("tie", 32'h3F80_0003, 32'h3FC0_0000, 4'h6, 32'h3FC0_0005, 4'h1);
`endif
    dir_op("ovf",     32'h7F00_0000, 32'h7F00_0000, 4'h7, 32'h7F80_0000, 4'h5);
    dir_op("unf",     32'h0080_0000, 32'h0080_0000, 4'h8, 32'h0000_0000, 4'h3);
    dir_op("inf_x_0", 32'h7F80_0000, 32'h0000_0000, 4'h9, 32'h7FC0_0000, 4'h8);
    dir_op("ninf_x2", 32'hFF80_0000, 32'h4000_0000, 4'hA, 32'hFF80_0000, 4'h0);

    // Stream of 8 with out_ready low in cycles 4-7
    cyc = 0; sent = 0; a = gen_op(); b = gen_op();
    while (sent < 8 && cyc < 100) begin
      in_valid = 1'b1; in_a = a; in_b = b; in_tag = 4'(sent);
      out_ready = !(cyc >= 4 && cyc <= 7);
      @(negedge clk);
      if (cyc >= 4 && cyc <= 7) chk("stall_in_ready", 64'(in_ready), 64'd0);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin sent++; a = gen_op(); b = gen_op(); end
      cyc++;
    end
    chk("stream_sent", 64'(sent), 64'd8);
    drain("stream");

    // Randomised traffic with random backpressure
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_a = gen_op(); in_b = gen_op(); in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    drain("random");

    // Reset with 3 operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h3F80_0000 + 32'(i); in_tag = 4'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valid",  64'(out_valid),  64'd0);
    chk("midrst_result", 64'(out_result), 64'd0);
    chk("midrst_tag",    64'(out_tag),    64'd0);
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("midrst_no_stale", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
